serial_capture_reg: RTL and testbench
=====================================

# serial_capture_reg

- Receive end of the on-chip bit-serial link driven by `rotate_reg`.
- The transmitter taps `data_out[0]` of `rotate_reg` while `sh` is high, so bits arrive LSB first, one per enabled cycle. This block reassembles them into `bit_width`-bit words.
- It holds each completed word for a consumer with a valid/ack handshake and flags words lost to an unconsumed holding register.
- It sits between the serial link and the parallel datapath.

## Interface

Parameters:
- `bit_width`, default 16: word width in bits, must be at least 2.
- `cnt_w`, default `$clog2(bit_width)`: width of the bit counter.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `clr`: input, 1 bit. Synchronous resync; aborts the partial word and clears all state, like `rst`.
- `en`: input, 1 bit. Serial bit valid this cycle.
- `sin`: input, 1 bit. Serial data bit, LSB of the word first.
- `rd_ack`: input, 1 bit. Consumer accepts the held word.
- `data_out`: output, `bit_width` bits. Holding register with the last completed word.
- `valid`: output, 1 bit. `data_out` holds an unconsumed word.
- `ovf`: output, 1 bit. Sticky flag: a completed word was dropped.
- `bit_cnt`: output, `cnt_w` bits. Number of bits of the current partial word received so far.

## Operation

Internal state:
- Shift register `sr` (`bit_width` bits).
- Counter `bit_cnt`.
- Holding register `data_out`.
- Flags `valid` and `ovf`.

Priority per rising edge: `rst`, then `clr`, then normal operation.
- `rst` or `clr` high: `sr`, `bit_cnt`, `data_out`, `valid` and `ovf` all go to 0. `en`, `sin` and `rd_ack` are ignored that cycle.

Shifting:
- `en`=1: `sr <= {sin, sr[bit_width-1:1]}`. The new bit enters at the MSB, so after `bit_width` shifts the first bit received sits at bit 0.
- `en`=0: `sr` and `bit_cnt` hold. Gaps of any length between bits are legal.

Counting:
- `en`=1 and `bit_cnt` < `bit_width-1`: `bit_cnt` increments.

Word completion (`en`=1 and `bit_cnt` = `bit_width-1`):
- The word `{sin, sr[bit_width-1:1]}` is complete and `bit_cnt` wraps to 0.
- If `valid`=0, or `rd_ack`=1 this cycle: `data_out` loads the completed word and `valid` is 1.
- If `valid`=1 and `rd_ack`=0: the completed word is dropped. `data_out` keeps the old word and `ovf` sets to 1.
- `sr` is not cleared at word completion; its contents are fully replaced over the next word.

Handshake:
- `rd_ack`=1 with `valid`=1 and no completion this cycle: `valid` goes to 0 and `data_out` holds its value.
- `rd_ack`=1 with `valid`=0 has no effect.
- `ovf` clears only on `rst` or `clr`.

States are implicit in `bit_cnt` (0 to `bit_width-1`) and `valid`; no further FSM is required.

## Timing

- Reset values: `data_out`=0, `valid`=0, `ovf`=0, `bit_cnt`=0.
- Latency: `valid` and `data_out` update on the same rising edge that samples the last bit (`en`=1, `bit_cnt`=`bit_width-1`). Both are visible in the following cycle.
- Minimum word period is `bit_width` cycles, with `en` held high continuously.
- A consumer that asserts `rd_ack` in the completion cycle of the next word sustains full rate with no gaps and no overflow.
- All outputs are registered; no combinational path from any input to any output.
- `rst` or `clr` asserted mid-word discards the partial word. The bit sampled with `en`=1 in the cycle after deassertion is bit 0 of a new word.

## Test plan

1. **Single word.** After reset, send 16'hA5C3 LSB first over 16 consecutive `en` cycles.
   - Required: after the 16th edge, `data_out`=16'hA5C3, `valid`=1, `bit_cnt`=0, `ovf`=0.
   - Then assert `rd_ack` for one cycle. Required: `valid`=0 and `data_out` still 16'hA5C3.
2. **Gapped input.** Send 16'h0F01 with `en` low for 3 cycles after every 4th bit.
   - Required: `data_out`=16'h0F01 and `valid`=1 exactly on the edge sampling bit 15.
   - `bit_cnt` holds its value during every gap.
3. **Back-to-back with ack.** Stream 16'h1234 then 16'hBEEF continuously, with `rd_ack`=1 in the completion cycle of the second word.
   - Required: `data_out`=16'hBEEF, `valid` stays 1 throughout, `ovf`=0.
4. **Overflow.** Stream 16'h1111 then 16'h2222 with no `rd_ack`.
   - Required: `data_out`=16'h1111, `valid`=1, `ovf`=1.
   - Then `rd_ack`: `valid`=0 and `ovf` stays 1. Then `clr`: `ovf`=0.
5. **Abort mid-word.** Pulse `clr` after 7 bits of 16'hFFFF, then send 16'h8001.
   - Required: `bit_cnt`=0 after `clr`; the captured word is 16'h8001, not a mix of the two words.
6. **Reset priority.** Assert `rst` in the completion cycle of 16'h5555, with `en`=1 and `rd_ack`=1.
   - Required: `data_out`=0, `valid`=0, `ovf`=0, `bit_cnt`=0 on the next cycle.
7. **Loopback.** Drive `sin` from `rotate_reg` `data_out[0]` (bit_width 16, loaded with 16'hC3A5, `en` tied to its `sh` for 16 cycles).
   - Required: `data_out`=16'hC3A5.

Source files
------------

// File: rtl/serial_capture_reg.sv
// Receive end of the LSB-first bit-serial link: reassembles bit_width-bit words
// and holds each one for a consumer behind a valid/ack handshake.
module serial_capture_reg #(
  parameter int bit_width = 16,
  parameter int cnt_w     = $clog2(bit_width)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 sin,
  input  logic                 rd_ack,
  output logic [bit_width-1:0] data_out,
  output logic                 valid,
  output logic                 ovf,
  output logic [cnt_w-1:0]     bit_cnt
);

  logic [bit_width-1:0] sr;
  logic [bit_width-1:0] word;
  logic                 last;

  // New bit enters at the MSB so the first bit received ends up at bit 0.
  assign word = {sin, sr[bit_width-1:1]};
  assign last = en && (bit_cnt == cnt_w'(bit_width - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr       <= '0;
      bit_cnt  <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (en) begin
        sr      <= word;
        bit_cnt <= last ? '0 : bit_cnt + cnt_w'(1);
      end
      // A completed word wins over a plain ack; an ack in the same cycle frees the slot for it.
      if (last) begin
        if (!valid || rd_ack) begin
          data_out <= word;
          valid    <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (rd_ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_capture_reg.sv
// Directed bench for serial_capture_reg with a scoreboard of expected captured words.
module tb_serial_capture_reg;

  logic        clk = 1'b0;
  logic        rst, clr, en, sin_drv, rd_ack;
  logic        lb_sel, sh;
  logic [15:0] rot;
  logic        sin;
  logic [15:0] data_out;
  logic        valid, ovf;
  logic [3:0]  bit_cnt;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  // Stand-in for the rotate_reg transmitter: rotates right while sh is high.
  always @(posedge clk) if (sh) rot <= {rot[0], rot[15:1]};

  assign sin = lb_sel ? rot[0] : sin_drv;

  serial_capture_reg #(.bit_width(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .sin(sin), .rd_ack(rd_ack),
    .data_out(data_out), .valid(valid), .ovf(ovf), .bit_cnt(bit_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic s, input logic a);
    en = e; sin_drv = s; rd_ack = a;
    @(posedge clk); #1;
    en = 1'b0; rd_ack = 1'b0;
  endtask

  task automatic chk_word(input string tag);
    logic [15:0] w;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s observed=%0h expected=queue_entry", tag, data_out);
    end else begin
      w = exp_q.pop_front();
      tests--;
      chk({tag, "_data"}, 32'(data_out), 32'(w));
      chk({tag, "_valid"}, 32'(valid), 32'd1);
    end
  endtask

  // Send a word LSB first; optional 3-cycle gaps after every 4th bit; optional ack on last bit.
  task automatic send(input logic [15:0] w, input bit gap, input bit ack_last, input bit chk_valid);
    logic [3:0] held;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, w[i], ack_last && (i == 15));
      if (chk_valid) chk("valid_stays", 32'(valid), 32'd1);
      if (gap && (i % 4 == 3) && (i != 15)) begin
        held = bit_cnt;
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b1, 1'b0);
          chk("gap_hold", 32'(bit_cnt), 32'(held));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; sin_drv = 1'b0; rd_ack = 1'b0;
    lb_sel = 1'b0; sh = 1'b0; rot = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_cnt", 32'(bit_cnt), 32'd0);
    rst = 1'b0;

    // Single word then ack
    exp_q.push_back(16'hA5C3);
    send(16'hA5C3, 1'b0, 1'b0, 1'b0);
    chk_word("t1");
    chk("t1_cnt", 32'(bit_cnt), 32'd0);
    chk("t1_ovf", 32'(ovf), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("t1_ack_valid", 32'(valid), 32'd0);
    chk("t1_ack_data", 32'(data_out), 32'hA5C3);

    // Gapped input; valid must stay low until the bit-15 edge
    exp_q.push_back(16'h0F01);
    for (int i = 0; i < 15; i++) begin
      step(1'b1, i[0] ? 1'b0 : 1'b0, 1'b0);
    end
    chk("t2_pre_valid", 32'(valid), 32'd0);
    // restart cleanly with the gapped word after a resync
    clr = 1'b1; step(1'b0, 1'b0, 1'b0); clr = 1'b0;
    send(16'h0F01, 1'b1, 1'b0, 1'b0);
    chk_word("t2");

    // Back-to-back with ack in the completion cycle of the second word
    step(1'b0, 1'b0, 1'b1);
    exp_q.push_back(16'h1234);
    send(16'h1234, 1'b0, 1'b0, 1'b0);
    chk_word("t3a");
    exp_q.push_back(16'hBEEF);
    send(16'hBEEF, 1'b0, 1'b1, 1'b1);
    chk_word("t3b");
    chk("t3_ovf", 32'(ovf), 32'd0);

    // Overflow
    step(1'b0, 1'b0, 1'b1);
    exp_q.push_back(16'h1111);
    send(16'h1111, 1'b0, 1'b0, 1'b0);
    send(16'h2222, 1'b0, 1'b0, 1'b0);
    chk_word("t4");
    chk("t4_ovf", 32'(ovf), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("t4_ack_valid", 32'(valid), 32'd0);
    chk("t4_ack_ovf", 32'(ovf), 32'd1);
    clr = 1'b1; step(1'b0, 1'b0, 1'b0); clr = 1'b0;
    chk("t4_clr_ovf", 32'(ovf), 32'd0);

    // Abort mid-word
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    chk("t5_cnt7", 32'(bit_cnt), 32'd7);
    clr = 1'b1; step(1'b1, 1'b1, 1'b0); clr = 1'b0;
    chk("t5_clr_cnt", 32'(bit_cnt), 32'd0);
    exp_q.push_back(16'h8001);
    send(16'h8001, 1'b0, 1'b0, 1'b0);
    chk_word("t5");

    // Reset wins over completion and ack
    for (int i = 0; i < 15; i++) step(1'b1, i[0] ? 1'b0 : 1'b1, 1'b0);
    rst = 1'b1; step(1'b1, 1'b0, 1'b1); rst = 1'b0;
    chk("t6_data", 32'(data_out), 32'h0);
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_ovf", 32'(ovf), 32'd0);
    chk("t6_cnt", 32'(bit_cnt), 32'd0);

    // Loopback from the rotating transmitter
    rot = 16'hC3A5; lb_sel = 1'b1;
    exp_q.push_back(16'hC3A5);
    sh = 1'b1; en = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    sh = 1'b0; en = 1'b0; lb_sel = 1'b0;
    chk_word("t7");
    chk("t7_rot_back", 32'(rot), 32'hC3A5);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
